// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply / restoring divide, one bit per clock, on operand magnitudes.
// Define MULDIV_SIGNED_EN to compile in signed MUL/DIV (op 00/10); otherwise they run unsigned.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div, div_zero;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo, a_raw;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH:0]   add_sum, shl_rem, trial, mul_top;
    logic             last_iter, b_zero;

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign b_zero    = (b == '0);
    assign busy      = (state != IDLE);

`ifdef MULDIV_SIGNED_EN
    logic sgn_op, a_neg_in, b_neg_in;
    logic neg_a, neg_b;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn_op   = ~op[0];
    assign a_neg_in = sgn_op & a[WIDTH-1];
    assign b_neg_in = sgn_op & b[WIDTH-1];
    assign a_mag    = a_neg_in ? -a : a;
    assign b_mag    = b_neg_in ? -b : b;
`else
    logic unused_op;

    assign unused_op = op[0];
    assign a_mag     = a;
    assign b_mag     = b;
`endif

    // Multiply keeps the multiplier in acc_lo and shifts product bits in from the top;
    // divide shifts the dividend out of acc_lo into the partial remainder in acc_hi.
    assign add_sum = {1'b0, acc_hi} + {1'b0, opnd};
    assign mul_top = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    assign shl_rem = {acc_hi, acc_lo[WIDTH-1]};
    assign trial   = shl_rem - {1'b0, opnd};

    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        prod_fix = {acc_hi, acc_lo};
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else if (is_div) begin
            res_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
            res_hi = neg_a ? -acc_hi : acc_hi;
        end else begin
            if (neg_a ^ neg_b)
                prod_fix = -{acc_hi, acc_lo};
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
`else
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (op[1] && b_zero) ? FIX : RUN;
            RUN:  if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            a_raw    <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            dz       <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_div   <= op[1];
                    div_zero <= op[1] & b_zero;
                    a_raw    <= a;
                    opnd     <= op[1] ? b_mag : a_mag;
                    acc_hi   <= '0;
                    acc_lo   <= op[1] ? a_mag : b_mag;
                    cnt      <= '0;
`ifdef MULDIV_SIGNED_EN
                    neg_a    <= a_neg_in;
                    neg_b    <= b_neg_in;
`endif
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        if (!trial[WIDTH]) begin
                            acc_hi <= trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= shl_rem[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_top, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    dz   <= div_zero;
                    done <= 1'b1;
                    cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: WIDTH=32 and WIDTH=8 instances, hand-computed vectors.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
    );

    muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dz(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency counts the capture edge as 1; inputs are scrambled right after capture.
    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int elat, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int lat;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 1;
        check({tag, "_busy"}, busy, 1);
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_dz"}, dz, edz);
        check({tag, "_idle"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_hold"}, {hi, lo}, {ehi, elo});
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int elat, input logic [7:0] ehi, input logic [7:0] elo);
        int lat;
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~x; b8 = ~y;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hi"}, hi8, ehi);
        check({tag, "_lo"}, lo8, elo);
        check({tag, "_dz"}, dz8, 0);
    endtask

    initial begin
        int lat;

        // reset with start held high: reset wins
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        start8 = 1'b1; op8 = 2'b01; a8 = 8'd5; b8 = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dz", dz, 0);
        check("rst8_out", {busy8, done8, dz8, hi8, lo8}, 0);
        @(negedge clk);
        start = 1'b0; start8 = 1'b0; clr = 1'b1;

        run32("mulu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MULDIV_SIGNED_EN
        run32("mul_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run32("mul_m4xm4", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 34, 32'h0, 32'h10, 1'b0);
        run32("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run32("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
`else
        run32("mul_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 34, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        run32("mul_m4xm4", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 34, 32'hFFFF_FFF8, 32'h10, 1'b0);
        run32("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        run32("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0, 1'b0);
`endif
        run32("divu_z", 2'b11, 32'd100, 32'd0, 2, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run32("divu_100d7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        run32("div_z", 2'b10, 32'd7, 32'd0, 2, 32'd7, 32'hFFFF_FFFF, 1'b1);

        // start re-asserted with new operands while busy
        @(negedge clk);
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b11; a = 32'd7; b = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        check("busy_hold", busy, 1);
        start = 1'b0;
        lat = 6;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_lat", lat, 34);
        check("busy_res", {hi, lo}, {32'd0, 32'd15});
        @(posedge clk); #1;
        check("busy_noq", busy, 0);

        // reset abort at iteration 10
        @(negedge clk);
        op = 2'b01; a = 32'h1234_5678; b = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        check("abort_out", {busy, done, dz, hi, lo}, 0);
        clr = 1'b1;
        run32("after_rst", 2'b01, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0);

        run8("mulu8", 2'b01, 8'd200, 8'd200, 10, 8'h9C, 8'h40);
        run8("divu8", 2'b11, 8'd200, 8'd7, 10, 8'h04, 8'h1C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand/dividend (Y-side operand).
REQ-007 SHALL have port b  input  WIDTH  multiplier/divisor (bus-side operand).
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  WIDTH  product upper half / remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half / quotient.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag for the last result.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after WIDTH iterations, FIX->IDLE unconditionally.
REQ-014 SHALL capture a, b, op on the edge at which start=1 in IDLE; later input changes SHALL NOT affect the result.
REQ-015 SHALL ignore start while busy=1 (no restart, no queuing).
REQ-016 SHALL hold busy=1 from the edge after capture until the edge on which done rises.
REQ-017 SHALL perform radix-2 shift-add multiply / restoring divide, one bit per clock, on operand magnitudes.
REQ-018 SHALL apply sign correction in FIX: product negated if operand signs differ; quotient sign = XOR of signs, truncated toward zero; remainder sign = dividend sign.
REQ-019 SHALL assert done for exactly one cycle, WIDTH+2 clocks after the capture edge, with hi/lo/dz valid in that cycle.
REQ-020 SHALL hold hi, lo, dz stable from done until the next capture edge.
REQ-021 SHALL, for DIV/DIVU with b=0, skip RUN, assert done 2 clocks after capture, set dz=1, lo=all ones, hi=a.
REQ-022 SHALL, for signed DIV of most-negative by -1, return lo=most-negative, hi=0, dz=0.
REQ-023 SHALL keep hi/lo full 2*WIDTH product exact for all operand values (no truncation).
REQ-024 SHALL treat start and clr=0 in the same cycle as reset only.

Reset
REQ-025 SHALL, on a clock edge with clr=0, enter IDLE and set busy=0, done=0, hi=0, lo=0, dz=0, iteration counter=0.
REQ-026 SHALL abort any operation in progress on reset without asserting done.
REQ-027 SHALL accept a new start on the first edge after clr returns to 1.

Configuration
REQ-028 SHALL use macro MULDIV_SIGNED_EN to compile signed support in or out.
REQ-029 SHALL, with MULDIV_SIGNED_EN defined, implement op 00/10 as signed per REQ-018/REQ-022.
REQ-030 SHALL, without MULDIV_SIGNED_EN, execute op 00 as MULU and op 10 as DIVU, with no sign-correction logic and unchanged latency.

Verification
REQ-031 SHALL cover: WIDTH=32, op=01, a=b=0xFFFFFFFF -> done 34 clocks after capture, hi=0xFFFFFFFE, lo=0x00000001, dz=0.
REQ-032 SHALL cover: WIDTH=32, op=00, a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without MULDIV_SIGNED_EN -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-033 SHALL cover: WIDTH=32, op=10, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; op=10, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: op=11, a=100, b=0 -> done 2 clocks after capture, dz=1, lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 SHALL cover: start re-asserted with new operands while busy -> first result unchanged; clr=0 at iteration 10 -> no done, all outputs 0, next start completes normally.
REQ-036 SHALL cover: WIDTH=8, op=01, a=200, b=200 -> done 10 clocks after capture, hi=0x9C, lo=0x40.
